// File: rtl/fsm_seq_checker.sv
// Receive-side monitor for a 2-bit free-running counter (00->01->10->11->00).
// Define SEQ_CHECK_STICKY_ERR_EN to make err_sticky latch the first locked-mode violation.
module fsm_seq_checker #(
  parameter int LOCK_CNT = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       seq_in,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [1:0]       expected,
  output logic [CNT_W-1:0] wrap_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    TRACK  = 2'b01,
    LOCKED = 2'b10
  } state_e;

  localparam logic [3:0]       LOCK_CNT_L = 4'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [1:0]       expected_q, expected_d;
  logic [CNT_W-1:0] wrap_count_q, wrap_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             err_pulse_q, err_pulse_d;
  logic             locked_q, locked_d;
  logic             seq_match;
  logic [1:0]       seq_next;

  assign seq_match = (seq_in == expected_q);
  assign seq_next  = seq_in + 2'd1;

  // Next-state and counter update; every valid sample re-anchors expected on seq_in.
  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    expected_d   = expected_q;
    wrap_count_d = wrap_count_q;
    err_count_d  = err_count_q;
    err_pulse_d  = 1'b0;
    case (state_q)
      HUNT: begin
        if (in_valid) begin
          expected_d  = seq_next;
          match_cnt_d = 4'd0;
          state_d     = TRACK;
        end else begin
          state_d = HUNT;
        end
      end
      TRACK: begin
        if (in_valid) begin
          expected_d = seq_next;
          if (seq_match) begin
            match_cnt_d = match_cnt_q + 4'd1;
            if ((match_cnt_q + 4'd1) == LOCK_CNT_L) begin
              state_d = LOCKED;
            end else begin
              state_d = TRACK;
            end
          end else begin
            match_cnt_d = 4'd0;
          end
        end else begin
          state_d = TRACK;
        end
      end
      LOCKED: begin
        if (in_valid) begin
          expected_d = seq_next;
          if (seq_match) begin
            if ((seq_in == 2'd0) && (wrap_count_q != CNT_MAX)) begin
              wrap_count_d = wrap_count_q + CNT_ONE;
            end else begin
              wrap_count_d = wrap_count_q;
            end
          end else begin
            // The offending value becomes the new reference for re-acquisition.
            err_pulse_d = 1'b1;
            match_cnt_d = 4'd0;
            state_d     = TRACK;
            if (err_count_q != CNT_MAX) begin
              err_count_d = err_count_q + CNT_ONE;
            end else begin
              err_count_d = err_count_q;
            end
          end
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
    locked_d = (state_d == LOCKED);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      match_cnt_q  <= 4'd0;
      expected_q   <= 2'd0;
      wrap_count_q <= '0;
      err_count_q  <= '0;
      err_pulse_q  <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      expected_q   <= expected_d;
      wrap_count_q <= wrap_count_d;
      err_count_q  <= err_count_d;
      err_pulse_q  <= err_pulse_d;
      locked_q     <= locked_d;
    end
  end

`ifdef SEQ_CHECK_STICKY_ERR_EN
  logic err_sticky_q;

  // Sticky flag survives relock; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
    end else if (err_pulse_d) begin
      err_sticky_q <= 1'b1;
    end else begin
      err_sticky_q <= err_sticky_q;
    end
  end

  assign err_sticky = err_sticky_q;
`else
  assign err_sticky = 1'b0;
`endif

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign expected   = expected_q;
  assign wrap_count = wrap_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_fsm_seq_checker.sv
// Directed bench for fsm_seq_checker (LOCK_CNT=3, CNT_W=2 so both counters saturate at 3).
module tb_fsm_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] seq_in = 2'd0;
  logic       locked, err_pulse, err_sticky;
  logic [1:0] expected, wrap_count, err_count;

  int errors = 0;
  int checks = 0;

`ifdef SEQ_CHECK_STICKY_ERR_EN
  localparam logic STICKY_EN = 1'b1;
`else
  localparam logic STICKY_EN = 1'b0;
`endif

  typedef struct packed {
    logic       lck;
    logic       pls;
    logic       stk;
    logic [1:0] exp_v;
    logic [1:0] wrp;
    logic [1:0] err;
  } exp_t;

  exp_t sb_q[$];
  logic err_seen = 1'b0;

  fsm_seq_checker #(.LOCK_CNT(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .seq_in(seq_in),
    .locked(locked), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .expected(expected), .wrap_count(wrap_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_locked"}, 8'(locked), 8'd0);
    chk({tag, "_pulse"}, 8'(err_pulse), 8'd0);
    chk({tag, "_sticky"}, 8'(err_sticky), 8'd0);
    chk({tag, "_expected"}, 8'(expected), 8'd0);
    chk({tag, "_wrap"}, 8'(wrap_count), 8'd0);
    chk({tag, "_err"}, 8'(err_count), 8'd0);
  endtask

  // Drive one sample, queue its expected response, compare one edge later.
  task automatic step(input string tag, input logic v, input logic [1:0] s,
                      input logic el, input logic ep, input logic [1:0] ee,
                      input logic [1:0] ew, input logic [1:0] er);
    exp_t e;
    exp_t got;
    in_valid = v;
    seq_in   = s;
    if (ep) err_seen = 1'b1;
    e.lck = el; e.pls = ep; e.stk = STICKY_EN & err_seen;
    e.exp_v = ee; e.wrp = ew; e.err = er;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 8'd1, 8'd0);
    end else begin
      got = sb_q.pop_front();
      chk({tag, "_locked"}, 8'(locked), 8'(got.lck));
      chk({tag, "_pulse"}, 8'(err_pulse), 8'(got.pls));
      chk({tag, "_sticky"}, 8'(err_sticky), 8'(got.stk));
      chk({tag, "_expected"}, 8'(expected), 8'(got.exp_v));
      chk({tag, "_wrap"}, 8'(wrap_count), 8'(got.wrp));
      chk({tag, "_err"}, 8'(err_count), 8'(got.err));
    end
  endtask

  initial begin
    #2;
    chk_reset("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Lock acquisition then one wrap
    step("acq0", 1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0);
    step("acq1", 1'b1, 2'd1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0);
    step("acq2", 1'b1, 2'd2, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0);
    step("acq3", 1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
    step("wrap1", 1'b1, 2'd0, 1'b1, 1'b0, 2'd1, 2'd1, 2'd0);
    // Violation and relock
    step("viol1", 1'b1, 2'd2, 1'b0, 1'b1, 2'd3, 2'd1, 2'd1);
    step("rl1a", 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1);
    step("rl1b", 1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd1);
    step("rl1c", 1'b1, 2'd1, 1'b1, 1'b0, 2'd2, 2'd1, 2'd1);
    // Gating: nothing moves while in_valid is low
    for (int i = 0; i < 5; i++) begin
      step("gate", 1'b0, 2'($urandom_range(3, 0)), 1'b1, 1'b0, 2'd2, 2'd1, 2'd1);
    end
    // Drive wrap_count into saturation
    step("w2a", 1'b1, 2'd2, 1'b1, 1'b0, 2'd3, 2'd1, 2'd1);
    step("w2b", 1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 2'd1, 2'd1);
    step("wrap2", 1'b1, 2'd0, 1'b1, 1'b0, 2'd1, 2'd2, 2'd1);
    step("w3a", 1'b1, 2'd1, 1'b1, 1'b0, 2'd2, 2'd2, 2'd1);
    step("w3b", 1'b1, 2'd2, 1'b1, 1'b0, 2'd3, 2'd2, 2'd1);
    step("w3c", 1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 2'd2, 2'd1);
    step("wrap3", 1'b1, 2'd0, 1'b1, 1'b0, 2'd1, 2'd3, 2'd1);
    step("w4a", 1'b1, 2'd1, 1'b1, 1'b0, 2'd2, 2'd3, 2'd1);
    step("w4b", 1'b1, 2'd2, 1'b1, 1'b0, 2'd3, 2'd3, 2'd1);
    step("w4c", 1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 2'd3, 2'd1);
    step("wrapsat", 1'b1, 2'd0, 1'b1, 1'b0, 2'd1, 2'd3, 2'd1);
    // Four more violations: err_count saturates at 3
    step("viol2", 1'b1, 2'd3, 1'b0, 1'b1, 2'd0, 2'd3, 2'd2);
    step("rl2a", 1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 2'd3, 2'd2);
    step("rl2b", 1'b1, 2'd1, 1'b0, 1'b0, 2'd2, 2'd3, 2'd2);
    step("rl2c", 1'b1, 2'd2, 1'b1, 1'b0, 2'd3, 2'd3, 2'd2);
    step("viol3", 1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 2'd3, 2'd3);
    step("rl3a", 1'b1, 2'd1, 1'b0, 1'b0, 2'd2, 2'd3, 2'd3);
    step("rl3b", 1'b1, 2'd2, 1'b0, 1'b0, 2'd3, 2'd3, 2'd3);
    step("rl3c", 1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 2'd3, 2'd3);
    step("viol4", 1'b1, 2'd2, 1'b0, 1'b1, 2'd3, 2'd3, 2'd3);
    step("rl4a", 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 2'd3, 2'd3);
    step("rl4b", 1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 2'd3, 2'd3);
    step("rl4c", 1'b1, 2'd1, 1'b1, 1'b0, 2'd2, 2'd3, 2'd3);
    step("viol5", 1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 2'd3, 2'd3);
    step("rl5a", 1'b1, 2'd1, 1'b0, 1'b0, 2'd2, 2'd3, 2'd3);
    step("rl5b", 1'b1, 2'd2, 1'b0, 1'b0, 2'd3, 2'd3, 2'd3);
    step("rl5c", 1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 2'd3, 2'd3);
    // Async reset while err_pulse is high
    step("viol6", 1'b1, 2'd1, 1'b0, 1'b1, 2'd2, 2'd3, 2'd3);
    #2 rst = 1'b1;
    #1;
    chk_reset("midrst");
    err_seen = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    // Pre-lock mismatch restarts the run without flagging
    step("pre0", 1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0);
    step("pre1", 1'b1, 2'd1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0);
    step("pre3", 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    step("pre0b", 1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0);
    step("pre1b", 1'b1, 2'd1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0);
    step("pre2", 1'b1, 2'd2, 1'b1, 1'b0, 2'd3, 2'd0, 2'd0);
    step("idle", 1'b0, 2'd0, 1'b1, 1'b0, 2'd3, 2'd0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_seq_checker.md
# fsm_seq_checker

Receive-side monitor for the 2-bit free-running state counter (sequence 00→01→10→11→00). It samples the counter's output bus and tracks the next expected value. It locks after a programmable run of correct transitions, then flags and counts every sequence violation and every completed wrap. It sits beside the counter FSM in the lab designs and provides self-check and status outputs for LEDs and the testbench.

## Interface
- LOCK_CNT, 3: number of consecutive correct transitions required to lock; legal range 1..15.
- CNT_W, 8: width of the wrap and error counters.

- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  sample enable; seq_in is evaluated only on edges where it is 1.
- seq_in  in  2  counter value under test.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle pulse on a violation while locked.
- err_sticky  out  1  latched error flag (see Configuration).
- expected  out  2  next value the checker expects.
- wrap_count  out  CNT_W  completed 11→00 wraps seen while locked; saturating.
- err_count  out  CNT_W  violations seen while locked; saturating.

## Operation
- States: HUNT, TRACK, LOCKED. The state register is 2 bits. Unused encodings return to HUNT.
- Reset values: state=HUNT, locked=0, err_pulse=0, err_sticky=0, expected=00, wrap_count=0, err_count=0, internal match_cnt=0 (4 bits).
- in_valid=0: all state and counters hold, and err_pulse=0.
- HUNT, on a valid sample: expected ← seq_in+1 (mod 4), match_cnt ← 0, next state TRACK. No error is reported.
- TRACK, on a valid sample with seq_in==expected: match_cnt+1 and expected ← seq_in+1.
  - If match_cnt+1 == LOCK_CNT, go to LOCKED.
- TRACK, on a valid sample with a mismatch: expected ← seq_in+1 and match_cnt ← 0. Stay in TRACK. No err_pulse and no err_count change.
- LOCKED, on a valid sample with a match: expected ← seq_in+1.
  - If seq_in==00, wrap_count increments, saturating at 2^CNT_W−1.
- LOCKED, on a valid sample with a mismatch:
  - err_pulse=1 for exactly one cycle.
  - err_count increments, saturating.
  - err_sticky is set when enabled.
  - Next state TRACK with match_cnt ← 0 and expected ← seq_in+1, i.e. the mismatching value becomes the new reference.
- locked=1 exactly when state==LOCKED.
- Counters only change in LOCKED. They never reset except through rst.
- An async rst mid-operation, including while err_pulse is high, forces all reset values immediately.

## Timing
- All outputs are registered. The response to a sample appears after the same rising edge that sampled it, i.e. one clock of latency.
- With in_valid held high and a correct stream, locked rises on the edge that samples the (LOCK_CNT+1)-th value after reset.
- err_pulse is never high for two consecutive cycles unless two consecutive valid samples both mismatch while locked. That cannot happen, because the first mismatch exits LOCKED.
- The expected output is always the value that will be checked on the next valid edge.

## Configuration
- SEQ_CHECK_STICKY_ERR_EN defined: err_sticky is set on the edge that raises err_pulse. It then holds 1 until rst, and relocking does not clear it.
- SEQ_CHECK_STICKY_ERR_EN undefined: err_sticky is constant 0. The port remains, and no flop is inferred.

## Test plan
- Reset check: assert rst mid-cycle. All outputs go to reset values immediately (locked=0, expected=00, counts=0).
- Lock acquisition (LOCK_CNT=3, in_valid=1): drive 0,1,2,3.
  - locked=1 after the edge sampling 3, expected=00.
  - Then drive 0: wrap_count=1 and expected=01.
- Violation: once locked with expected=01, drive 10.
  - err_pulse=1 for one cycle, err_count=1, locked=0, expected=11.
  - Then drive 3,0,1: locked=1 again and err_count stays 1.
- Gating: once locked, drop in_valid for 5 cycles while seq_in toggles randomly. No output changes.
- Pre-lock mismatch: after reset drive 0,1,3,0,1,2.
  - No err_pulse occurs and err_count=0.
  - locked=1 after the edge sampling 2, because the run restarts at 3.
- Sticky and saturation (CNT_W=2, macro defined): force 5 violations while locked.
  - err_count saturates at 3.
  - err_sticky=1 and remains after relock. With the macro undefined, err_sticky=0 throughout.
